// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store controller driving a word-addressed data memory.
// Accepts one load/store at a time, converts byte addresses to doubleword
// indices, sequences read/write strobes, extracts/extends sub-word loads and
// returns a registered response with an error flag.
// Optional feature macro: LSU_RMW_EN (read-modify-write for sub-word stores).
//
// Handshake rules: a transfer happens on a rising edge where valid && ready
// are both high; valid, once raised, is held with its payload until that edge;
// ready may depend combinationally on state but never on valid.
module lsu_ctrl #(
  parameter int MEM_WORDS = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic [63:0] address,
  output logic [63:0] wrt_data,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [63:0] read_data,
  output logic [2:0]  o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_RESP = 3'd5
`ifdef LSU_RMW_EN
    , S_RMW_RD = 3'd3
    , S_RMW_WR = 3'd4
`endif
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [2:0]  r_off;
  logic [63:0] r_address;
  logic [63:0] r_wdata;
  logic [63:0] r_rdata;
  logic        r_err;
  logic        w_accept;
  logic        w_misalign;
  logic        w_oor;
  logic        w_bad_store;
  logic        w_err;
  logic [63:0] w_lane;
  logic [63:0] w_load;
`ifdef LSU_RMW_EN
  logic [63:0] r_merge;
  logic [63:0] w_mask_base;
  logic [63:0] w_mask;
  logic [63:0] w_merged;
`endif

  assign w_accept    = req_valid && (r_state == S_IDLE);
  assign o_dbg_state = r_state;

  // Acceptance-time error check: alignment, range and unsupported stores
  always_comb begin
    w_misalign = 1'b0;
    case (req_size)
      2'b01:   w_misalign = req_addr[0];
      2'b10:   w_misalign = |req_addr[1:0];
      2'b11:   w_misalign = |req_addr[2:0];
      default: w_misalign = 1'b0;
    endcase
    w_oor = ({3'b000, req_addr[63:3]} >= 64'(MEM_WORDS));
`ifdef LSU_RMW_EN
    w_bad_store = 1'b0;
`else
    // Without read-modify-write only full doubleword stores are possible
    w_bad_store = req_write && (req_size != 2'b11);
`endif
    w_err = w_misalign || w_oor || w_bad_store;
  end

  // Load lane select and sign/zero extension
  always_comb begin
    w_lane = read_data >> {r_off, 3'b000};
    case (r_size)
      2'b00:   w_load = r_unsigned ? {56'd0, w_lane[7:0]}  : {{56{w_lane[7]}}, w_lane[7:0]};
      2'b01:   w_load = r_unsigned ? {48'd0, w_lane[15:0]} : {{48{w_lane[15]}}, w_lane[15:0]};
      2'b10:   w_load = r_unsigned ? {32'd0, w_lane[31:0]} : {{32{w_lane[31]}}, w_lane[31:0]};
      default: w_load = w_lane;
    endcase
  end

`ifdef LSU_RMW_EN
  // Merge store bytes into the previously read doubleword
  always_comb begin
    case (r_size)
      2'b00:   w_mask_base = 64'h0000_0000_0000_00FF;
      2'b01:   w_mask_base = 64'h0000_0000_0000_FFFF;
      2'b10:   w_mask_base = 64'h0000_0000_FFFF_FFFF;
      default: w_mask_base = '1;
    endcase
    w_mask   = w_mask_base << {r_off, 3'b000};
    w_merged = (r_merge & ~w_mask) | ((r_wdata << {r_off, 3'b000}) & w_mask);
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and memory/handshake strobes
  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    wrt_data   = 64'd0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (w_accept) begin
          if (w_err)                  w_next = S_RESP;
          else if (!req_write)        w_next = S_RD;
          else if (req_size == 2'b11) w_next = S_WR;
`ifdef LSU_RMW_EN
          else                        w_next = S_RMW_RD;
`else
          else                        w_next = S_RESP;
`endif
        end
      end
      S_RD: begin
        mem_read = 1'b1;
        w_next   = S_RESP;
      end
      S_WR: begin
        mem_write = 1'b1;
        wrt_data  = r_wdata;
        w_next    = S_RESP;
      end
`ifdef LSU_RMW_EN
      S_RMW_RD: begin
        mem_read = 1'b1;
        w_next   = S_RMW_WR;
      end
      S_RMW_WR: begin
        mem_write = 1'b1;
        wrt_data  = w_merged;
        w_next    = S_RESP;
      end
`endif
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Request capture, load result and merge-word registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_off      <= 3'd0;
      r_address  <= 64'd0;
      r_wdata    <= 64'd0;
      r_rdata    <= 64'd0;
      r_err      <= 1'b0;
`ifdef LSU_RMW_EN
      r_merge    <= 64'd0;
`endif
    end else begin
      if (w_accept) begin
        r_size     <= req_size;
        r_unsigned <= req_unsigned;
        r_off      <= req_addr[2:0];
        r_address  <= {3'b000, req_addr[63:3]};
        r_wdata    <= req_wdata;
        r_rdata    <= 64'd0;
        r_err      <= w_err;
      end
      if (r_state == S_RD) r_rdata <= w_load;
`ifdef LSU_RMW_EN
      if (r_state == S_RMW_RD) r_merge <= read_data;
`endif
    end
  end

  assign address    = r_address;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store controller: the initiator that drives the `data_mem` port from the CPU datapath. It accepts one load or store request at a time through a valid/ready handshake. It converts byte addresses to doubleword indices, sequences the `mem_read` and `mem_write` strobes, and performs sub-word extraction and sign extension. It returns a registered response with an error flag for misaligned or out-of-range accesses.

## Interface
- `MEM_WORDS`, default 10: number of 64-bit words in the attached memory. Word indices at or above this value are out of range.
- `clk` input 1: clock. All state changes on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: controller can accept a request; equals (state == IDLE).
- `req_write` input 1: 1 = store, 0 = load.
- `req_size` input 2: 00 byte, 01 half, 10 word, 11 doubleword.
- `req_unsigned` input 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `req_addr` input 64: byte address.
- `req_wdata` input 64: store data. The low (8<<size) bits are used.
- `resp_valid` output 1: response present.
- `resp_ready` input 1: consumer accepts the response.
- `resp_rdata` output 64: load result after extension; 0 for stores and for errors.
- `resp_err` output 1: access rejected; no memory strobe was issued.
- `address` output 64: word index to memory, equal to `req_addr[63:3]` zero-extended.
- `wrt_data` output 64: write data to memory.
- `mem_write` output 1: write strobe. Memory writes on the rising edge while high.
- `mem_read` output 1: read enable. `read_data` is combinational from `address`.
- `read_data` input 64: memory read data.

## Operation
- Request fields are captured into registers on the handshake `req_valid && req_ready`. The memory-side outputs are driven only from these registers.
- Lane offset is `off = addr[2:0]`. Byte lanes are little-endian: byte k occupies bits [8k+7:8k].
- Error check at acceptance. An error is raised if either condition holds:
  - `addr` is not a multiple of (1<<size);
  - `addr[63:3] >= MEM_WORDS`.
- An error goes IDLE→RESP with `resp_err=1` and issues no strobe.
- FSM states: IDLE, RD, WR, RMW_RD, RMW_WR, RESP.
  - IDLE: on accept, go to one of:
    - RESP if error;
    - RD if load;
    - WR if doubleword store;
    - RMW_RD if sub-word store.
  - RD: `mem_read=1`. Lane-select, extend and capture `read_data` into `resp_rdata` at the end of the cycle. Next state is RESP.
  - WR: `mem_write=1`, `wrt_data=req_wdata`. Next state is RESP.
  - RMW_RD: `mem_read=1`. Capture `read_data` into the merge register. Next state is RMW_WR.
  - RMW_WR: `mem_write=1`. `wrt_data` is the merge register with bytes [off +: 1<<size] replaced by the low bytes of `req_wdata`. Next state is RESP.
  - RESP: `resp_valid=1`. On `resp_ready`, go to IDLE. Otherwise hold, with all response outputs stable.
- Load extension: the selected field is sign- or zero-extended to 64 bits according to `req_unsigned`. A doubleword load ignores `req_unsigned`.
- Outside RD, RMW_RD, WR and RMW_WR: `mem_read=0`, `mem_write=0`, `wrt_data=0`. `address` holds its last registered value.

## Timing
- Reset (`rst_n`=0 at an edge) sets:
  - state to IDLE;
  - `req_ready=1` (combinational from IDLE);
  - `resp_valid=0`, `resp_err=0`, `resp_rdata=0`;
  - `mem_read=0`, `mem_write=0`;
  - `address=0`, `wrt_data=0`.
- Reset mid-operation aborts the operation. If reset is asserted in the same cycle as the WR or RMW_WR strobe, the memory write is still seen at that edge. No response is produced for the aborted request.
- Latency, with accept at edge N:
  - load or doubleword store: strobe during cycle N+1, `resp_valid` from edge N+2;
  - sub-word store: read in N+1, write in N+2, `resp_valid` from N+3;
  - error: `resp_valid` from N+1.
- Throughput: one request outstanding. `req_ready=0` from acceptance until the cycle after the RESP handshake.
- `resp_valid && resp_ready` at edge M returns the FSM to IDLE. A new request can be accepted at M+1 at the earliest; there is no accept in the same cycle as the response handshake.
- `req_valid` with `req_ready=0` is ignored. The requester must hold it.

## Configuration
- `LSU_RMW_EN` defined: sub-word stores use the RMW_RD→RMW_WR sequence described above.
- `LSU_RMW_EN` undefined:
  - the RMW states are not built;
  - a store with `req_size != 11` is rejected as an error (IDLE→RESP, `resp_err=1`, no strobe);
  - sub-word loads are unaffected.

## Test plan
- Doubleword store then load:
  - store `addr=0x28`, `wdata=0x1122334455667788` → `mem_write` in one cycle with `address=5`, then `resp_err=0`;
  - load `addr=0x28`, size 11 → `resp_rdata=0x1122334455667788`.
- Signed and unsigned byte load, with word 6 = `0x00000000000080FF`:
  - `addr=0x31`, size 00, signed → `0xFFFFFFFFFFFFFF80`;
  - unsigned → `0x0000000000000080`.
- Sub-word store (with `LSU_RMW_EN`), with word 7 = `0xAAAAAAAAAAAAAAAA`:
  - half store `addr=0x3A`, `wdata=0x1234` → read then write cycles, word 7 = `0xAAAAAAAA1234AAAA`, `resp_valid` 3 cycles after accept;
  - without the macro → `resp_err=1` and no `mem_write`.
- Errors:
  - word load at `addr=0x2A` → `resp_err=1`, `mem_read` never high;
  - doubleword load at `addr=0x50` (index 10, `MEM_WORDS=10`) → `resp_err=1`.
- Backpressure: hold `resp_ready=0` for 5 cycles → `resp_valid` and `resp_rdata` stable, `req_ready=0` throughout. After the handshake, `req_ready=1` the next cycle.
- Reset during RMW_RD → next cycle IDLE with all outputs at reset values, no `mem_write`, and the target word unchanged.
